ooo_resp_engine: RTL

Responder-side model for the out-of-order result interface: it consumes single-cycle `vld_i` requests and returns one `vld_o`/`result` completion per accepted request after a per-request latency. Because latencies differ, completions leave out of order. It is the DUT end of the demo environment that exercises the out-of-order scoreboard; the bench drives `vld_i`, and the monitor/scoreboard observes `vld_o` and `result`.

---
 rtl/ooo_resp_engine_if.sv | 16 +
 rtl/ooo_resp_engine.sv | 110 +++++++++++
 2 files changed

// File: rtl/ooo_resp_engine_if.sv
// Request/completion bundle between the out-of-order responder and its driver/monitor.
// SLOTS must match the engine's SLOTS so pend_cnt has the right width.
interface ooo_resp_engine_if #(
  parameter int SLOTS = 4
);
  localparam int PEND_W = $clog2(SLOTS + 1);

  logic              vld_i;
  logic              vld_o;
  logic [3:0]        result;
  logic              drop_o;
  logic [PEND_W-1:0] pend_cnt;

  modport master (output vld_i, input vld_o, result, drop_o, pend_cnt);
  modport slave  (input vld_i, output vld_o, result, drop_o, pend_cnt);
endinterface

// File: rtl/ooo_resp_engine.sv
// Out-of-order responder: each accepted request waits a per-request latency in a slot,
// then its tag is returned; the lowest-index ready slot wins when several are ready.
module ooo_resp_engine #(
  parameter int         SLOTS     = 4,
  parameter int         MAX_LAT   = 8,
  parameter int         FIXED_LAT = 0,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  ooo_resp_engine_if.slave bus
);
  localparam int CNT_W  = $clog2(MAX_LAT + 1);
  localparam int LAT_W  = $clog2(MAX_LAT);
  localparam int PEND_W = $clog2(SLOTS + 1);
  localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef struct packed {
    logic             valid;
    logic [3:0]       tag;
    logic [CNT_W-1:0] cnt;
  } slot_t;

  slot_t [SLOTS-1:0] slot_q, slot_d;
  logic [3:0]        seq_q, seq_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              vld_q, vld_d;
  logic [3:0]        res_q, res_d;
  logic              drop_q, drop_d;
  logic [PEND_W-1:0] pend_q, pend_d;

  logic [CNT_W-1:0]  lat;
  logic              free_found, rdy_found, accept;
  logic [IDX_W-1:0]  free_idx, rdy_idx;

  always_comb begin
    if (FIXED_LAT != 0) lat = CNT_W'(FIXED_LAT);
    else                lat = CNT_W'(lfsr_q[LAT_W-1:0]) + CNT_W'(1);
  end

  // Both searches look at pre-edge state; scanning downwards leaves the lowest index selected.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (slot_q[i].valid && slot_q[i].cnt == '0) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
  always_comb begin
    slot_d = slot_q;
    seq_d  = seq_q;
    res_d  = res_q;
    accept = bus.vld_i && free_found;
    vld_d  = rdy_found;
    drop_d = bus.vld_i && !free_found;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q[i].valid && slot_q[i].cnt != '0) slot_d[i].cnt = slot_q[i].cnt - CNT_W'(1);
    end
    if (rdy_found) begin
      slot_d[rdy_idx].valid = 1'b0;
      res_d                 = slot_q[rdy_idx].tag;
    end
    // The free slot was invalid before the edge, so it never collides with the emitted one.
    if (accept) begin
      slot_d[free_idx].valid = 1'b1;
      slot_d[free_idx].tag   = seq_q;
      slot_d[free_idx].cnt   = lat;
      seq_d                  = seq_q + 4'd1;
    end
    pend_d = pend_q + PEND_W'(accept) - PEND_W'(rdy_found);
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // NOTE: the whole slot array is reset, so a reset discards pending requests and leaves no X tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      seq_q  <= '0;
      lfsr_q <= LFSR_SEED;
      vld_q  <= 1'b0;
      res_q  <= '0;
      drop_q <= 1'b0;
      pend_q <= '0;
    end else begin
      slot_q <= slot_d;
      seq_q  <= seq_d;
      lfsr_q <= lfsr_d;
      vld_q  <= vld_d;
      res_q  <= res_d;
      drop_q <= drop_d;
      pend_q <= pend_d;
    end
  end

  assign bus.vld_o    = vld_q;
  assign bus.result   = res_q;
  assign bus.drop_o   = drop_q;
  assign bus.pend_cnt = pend_q;
endmodule
